lut_mult_loader: RTL and testbench

- Sequential writer that generates and loads the two constant-multiplier LUTs: the 8-word direct LUT (k*A, k=0..7) and the 9-word OMS LUT ((2k+1)*A for k=0..7, then 2*A).
- Fills the tables for a runtime constant A using shift/add accumulation, with no multiplier.
- Drives a valid/ready write port that the LUT multiplier datapath's table storage consumes.
- Sits between the configuration logic and the LUT multiplier; one load is required per constant change.

---
 rtl/lut_mult_loader.sv | 186 ++++++++++++++++++
 tb/tb_lut_mult_loader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lut_mult_loader.sv
// lut_mult_loader
//   Generates and writes the two constant-multiplier tables for a runtime
//   constant A using shift/add accumulation (no multiplier):
//     direct LUT (wr_sel=0): addr k = k*A        for k = 0..7
//     OMS LUT    (wr_sel=1): addr k = (2k+1)*A   for k = 0..7, addr 8 = 2*A
//   Every load issues exactly 17 beats over a valid/ready write port.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle load request, accepted only in IDLE
//   a_const         constant A, captured on the accepted start
//   busy            high from the accepted start until the last beat is accepted
//   done            one-cycle pulse after the last beat is accepted
//   wr_valid/ready  write handshake; a beat transfers when both are high
//   wr_sel          0 = direct LUT, 1 = OMS LUT
//   wr_addr         word index within the selected LUT
//   wr_data         word value, zero-extended to D_W bits
//   csum            (LUT_LOADER_CHECKSUM_EN only) mod-2^16 sum of accepted wr_data
//
// Optional feature macro: LUT_LOADER_CHECKSUM_EN adds the csum output.

module lut_mult_loader #(
    parameter int A_W                = 8,
    parameter int D_W                = A_W + 4,
    parameter int PAUSE_ON_READY_LOW = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [A_W-1:0] a_const,
    output logic           busy,
    output logic           done,
    output logic           wr_valid,
    input  logic           wr_ready,
    output logic           wr_sel,
    output logic [3:0]     wr_addr,
    output logic [D_W-1:0] wr_data
`ifdef LUT_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]    csum
`endif
);

    // Beats are held until accepted; no other backpressure mode exists.
    if (PAUSE_ON_READY_LOW != 1) begin : g_param_check
        $error("lut_mult_loader: PAUSE_ON_READY_LOW must be 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        DIRECT,
        OMS,
        OMS_LAST,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [A_W-1:0] a_reg;
    logic [D_W-1:0] acc_d;
    logic [D_W-1:0] acc_o;
    logic [3:0]     addr;
    logic [D_W-1:0] a_ext;
    logic [D_W-1:0] two_a;
    logic           accept;

    assign a_ext  = D_W'(a_reg);
    assign two_a  = D_W'({a_reg, 1'b0});
    assign accept = wr_valid && wr_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs. All outputs decode from registered state, so
    // they are inherently stable while a beat waits for wr_ready.
    always_comb begin
        state_next = state;
        wr_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        wr_sel     = 1'b0;
        wr_addr    = addr;
        wr_data    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DIRECT;
                end
            end
            DIRECT: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                wr_data  = acc_d;
                if (accept && addr == 4'd7) begin
                    state_next = OMS;
                end
            end
            OMS: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                wr_sel   = 1'b1;
                wr_data  = acc_o;
                if (accept && addr == 4'd7) begin
                    state_next = OMS_LAST;
                end
            end
            OMS_LAST: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                wr_sel   = 1'b1;
                wr_data  = two_a;
                if (accept) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Constant register, accumulators and word index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            acc_d <= '0;
            acc_o <= '0;
            addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_const;
                        acc_d <= '0;
                        acc_o <= D_W'(a_const);
                        addr  <= '0;
                    end
                end
                DIRECT: begin
                    if (accept) begin
                        acc_d <= acc_d + a_ext;
                        // Wrap to 0 so the OMS table starts at its first word.
                        addr  <= (addr == 4'd7) ? 4'd0 : addr + 4'd1;
                    end
                end
                OMS: begin
                    if (accept) begin
                        // Odd multiples step by 2A; 7 -> 8 lands on the 2A word.
                        acc_o <= acc_o + two_a;
                        addr  <= addr + 4'd1;
                    end
                end
                OMS_LAST: begin
                    if (accept) begin
                        addr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LUT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + 16'(wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_lut_mult_loader.sv
module tb_lut_mult_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a_const;
    logic        busy;
    logic        done;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [15:0] csum;
`endif

    int n_total = 0;
    int n_bad   = 0;

    lut_mult_loader #(
        .A_W(8),
        .D_W(12),
        .PAUSE_ON_READY_LOW(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_const  (a_const),
        .busy     (busy),
        .done     (done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
`ifdef LUT_LOADER_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Hand-derived table contents for beat index i of a load with constant a.
    function automatic int exp_data(input int a, input int i);
        if (i < 8)       return i * a;
        else if (i < 16) return (2 * (i - 8) + 1) * a;
        else             return 2 * a;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(wr_valid), 0);
        check({tag, "_busy"},  32'(busy),     0);
        check({tag, "_done"},  32'(done),     0);
        check({tag, "_sel"},   32'(wr_sel),   0);
        check({tag, "_addr"},  32'(wr_addr),  0);
        check({tag, "_data"},  32'(wr_data),  0);
`ifdef LUT_LOADER_CHECKSUM_EN
        check({tag, "_csum"},  32'(csum),     0);
`endif
    endtask

    // Runs one load from IDLE; called and returns on a negative clock edge.
    // s1/s2: beat index and number of wr_ready-low cycles before acceptance.
    // mid_beat: beat at which a second start (a_const=9) is pulsed.
    // abort_beat: beat at which rst_n is asserted and the load abandoned.
    task automatic run_load(input int a, input int mid_beat,
                            input int s1_beat, input int s1_len,
                            input int s2_beat, input int s2_len,
                            input int abort_beat, input bit start_in_done);
        int beat = 0;
        int st = 0;
        int cyc = 0;
        int busy_cycles = 0;
        int exp_sum = 0;
        bit rdy;
        start    = 1'b1;
        a_const  = 8'(a);
        wr_ready = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        a_const = 8'h5A;
        while (beat < 17 && cyc < 300) begin
            if (beat == abort_beat) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            start = (beat == mid_beat && st == 0) ? 1'b1 : 1'b0;
            if (start) a_const = 8'd9;
            rdy = !((beat == s1_beat && st < s1_len) || (beat == s2_beat && st < s2_len));
            wr_ready = rdy;
            if (busy) busy_cycles++;
            check($sformatf("valid_b%0d", beat), 32'(wr_valid), 1);
            check($sformatf("sel_b%0d", beat),   32'(wr_sel), (beat >= 8) ? 1 : 0);
            check($sformatf("addr_b%0d", beat),  32'(wr_addr), (beat < 8) ? beat : beat - 8);
            check($sformatf("data_b%0d", beat),  32'(wr_data), exp_data(a, beat));
            check($sformatf("done_b%0d", beat),  32'(done), 0);
            if (rdy) begin
                exp_sum += exp_data(a, beat);
                beat++;
                st = 0;
            end else begin
                st++;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        wr_ready = 1'b1;
        check("beats_accepted", 32'(beat), 17);
        check("busy_cycles", 32'(busy_cycles), 32'(17 + s1_len + s2_len));
        check("done_pulse", 32'(done), 1);
        check("busy_at_done", 32'(busy), 0);
        check("valid_at_done", 32'(wr_valid), 0);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("csum", 32'(csum), 32'(exp_sum % 65536));
`endif
        if (start_in_done) begin
            start   = 1'b1;
            a_const = 8'd77;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_cleared", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_valid", 32'(wr_valid), 0);
`ifdef LUT_LOADER_CHECKSUM_EN
        check("csum_hold", 32'(csum), 32'(exp_sum % 65536));
`endif
        @(negedge clk);
        check("idle_busy2", 32'(busy), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a_const  = 8'd0;
        wr_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        // basic load, A=2
        run_load(2, -1, -1, 0, -1, 0, -1, 1'b0);
        // largest constant, no truncation (1785, 3825, 510)
        run_load(255, -1, -1, 0, -1, 0, -1, 1'b0);
        // stalls: 3 cycles at direct addr 4, 2 cycles at OMS addr 8
        run_load(5, -1, 4, 3, 16, 2, -1, 1'b0);
        // start ignored mid-load
        run_load(3, 5, -1, 0, -1, 0, -1, 1'b0);
        // reset at OMS addr 2, then full reload with A=1
        run_load(7, -1, -1, 0, -1, 0, 10, 1'b0);
        run_load(1, -1, -1, 0, -1, 0, -1, 1'b0);
        // A=0 with a start pulse in the done cycle (must be ignored)
        run_load(0, -1, -1, 0, -1, 0, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
